// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider.
// Optional divide-by-zero early-out lives in div_iter under DIV_DBZ_EN.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);
    // Widest operand the packing helper supports.
    localparam int unsigned DIV_MAX_W = 64;

    typedef logic [1:0] div_state_t;
    localparam div_state_t ST_IDLE = 2'd0;
    localparam div_state_t ST_CALC = 2'd1;
    localparam div_state_t ST_FIX  = 2'd2;

    // HI = remainder, LO = quotient; w is the real operand width.
    function automatic logic [2*DIV_MAX_W-1:0] div_pack_hilo(
        input logic [DIV_MAX_W-1:0] rem,
        input logic [DIV_MAX_W-1:0] quo,
        input int unsigned          w
    );
        return ({{DIV_MAX_W{1'b0}}, rem} << w) | {{DIV_MAX_W{1'b0}}, quo};
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// subtract the divisor if it fits, emit the quotient bit.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             quo_bit_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    always_comb begin
        shifted   = {rem_i, bit_i};
        // When the divisor fits, the true difference is below the divisor,
        // so the low WIDTH bits of the subtraction are exact.
        diff      = shifted[WIDTH-1:0] - divisor_i;
        quo_bit_o = (shifted >= {1'b0, divisor_i});
        rem_o     = quo_bit_o ? diff : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_iter.sv
// Iterative restoring DIV/DIVU unit, one quotient bit per cycle, HI/LO output.
// Define DIV_DBZ_EN for the zero-divisor early-out and the dbz flag.
module div_iter
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    input  logic                 flush,
    output logic                 busy,
    output logic                 stallreq,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic [2*WIDTH-1:0]   hilo
`ifdef DIV_DBZ_EN
    ,
    output logic                 dbz
`endif
);

    localparam int unsigned CntW = $clog2(WIDTH);

    div_state_t       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;       // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] res_rem_q, res_rem_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             done_q, done_d;
`ifdef DIV_DBZ_EN
    logic             zdiv_q, zdiv_d;
    logic             dbz_q, dbz_d;
`endif

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH-1:0] step_rem;
    logic             step_bit;

    assign a_neg = signed_op & dividend[WIDTH-1];
    assign b_neg = signed_op & divisor[WIDTH-1];
    assign a_abs = a_neg ? (~dividend + 1'b1) : dividend;
    assign b_abs = b_neg ? (~divisor + 1'b1) : divisor;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i    (rem_q),
        .bit_i    (dvd_q[WIDTH-1]),
        .divisor_i(dvs_q),
        .rem_o    (step_rem),
        .quo_bit_o(step_bit)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        quo_d     = quo_q;
        res_rem_d = res_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        done_d    = 1'b0;
`ifdef DIV_DBZ_EN
        zdiv_d    = zdiv_q;
        dbz_d     = dbz_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    dvs_d     = b_abs;
                    dvd_d     = a_abs;
                    rem_d     = '0;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    cnt_d     = '0;
                    state_d   = ST_CALC;
`ifdef DIV_DBZ_EN
                    zdiv_d    = (divisor == '0);
                    if (divisor == '0) begin
                        dvd_d   = dividend;
                        state_d = ST_FIX;
                    end
`endif
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    rem_d = step_rem;
                    dvd_d = {dvd_q[WIDTH-2:0], step_bit};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!flush) begin
                    quo_d     = neg_quo_q ? (~dvd_q + 1'b1) : dvd_q;
                    res_rem_d = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
                    done_d    = 1'b1;
`ifdef DIV_DBZ_EN
                    dbz_d     = zdiv_q;
                    if (zdiv_q) begin
                        quo_d     = '1;
                        res_rem_d = dvd_q;
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            quo_q     <= '0;
            res_rem_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef DIV_DBZ_EN
            zdiv_q    <= 1'b0;
            dbz_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            quo_q     <= quo_d;
            res_rem_q <= res_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            done_q    <= done_d;
`ifdef DIV_DBZ_EN
            zdiv_q    <= zdiv_d;
            dbz_q     <= dbz_d;
`endif
        end
    end

    assign busy      = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign stallreq  = ((state_q == ST_IDLE) && start && !flush) || busy;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = res_rem_q;
    assign hilo      = (2*WIDTH)'(div_pack_hilo(DIV_MAX_W'(res_rem_q), DIV_MAX_W'(quo_q), WIDTH));
`ifdef DIV_DBZ_EN
    assign dbz       = dbz_q;
`endif

endmodule

// File: doc/div_iter.md
# div_iter

Iterative restoring divider for the execute stage, parametrised in operand width, producing a packed HI/LO result for DIV/DIVU. It accepts one operation on a start strobe and computes one quotient bit per cycle. It holds the execute stage through a stall request until completion and drops the operation on a pipeline flush. It sits beside the execute-stage ALU and feeds the HI/LO write path.

## Interface
- WIDTH, 32, operand/quotient/remainder width (≥ 4)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a division; sampled only in IDLE
- signed_op  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
- dividend  in  WIDTH  sampled with start
- divisor  in  WIDTH  sampled with start
- flush  in  1  annul current operation (exception/flush_im)
- busy  out  1  operation in progress
- stallreq  out  1  stall request to the stall control unit
- done  out  1  one-cycle result-valid pulse
- quotient  out  WIDTH  result, held until next accepted start
- remainder  out  WIDTH  result, held until next accepted start
- hilo  out  2·WIDTH  {remainder, quotient} (HI = remainder, LO = quotient)
- dbz  out  1  divide-by-zero flag; only present with DIV_DBZ_EN

## Operation
- States:
  - IDLE: start & ~flush → latch |dividend|, |divisor|, sign info, count = 0 → CALC.
  - CALC: one restoring step per cycle, shifting the partial remainder and subtracting the divisor. When count = WIDTH−1 → FIX. Any cycle with flush → IDLE.
  - FIX: apply sign correction, register results, assert done → IDLE.
- Signed rules:
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Magnitudes are treated as unsigned WIDTH-bit values, so the most negative value is handled.
- Overflow: most-negative ÷ −1 gives quotient = most-negative, remainder = 0, with wrap-around and no flag.
- Divide by zero without the macro: the full iteration runs. Result: quotient = all ones before sign fixup, remainder = dividend.
- stallreq = (IDLE & start & ~flush) | CALC | FIX, i.e. asserted from the start cycle through the done cycle inclusive.
- busy = CALC | FIX.
- start while busy is ignored, with no queuing.
- start & flush in the same cycle: flush wins and the operation is not accepted.
- flush in FIX: done is suppressed and results are not updated.
- Reset: state = IDLE. busy, stallreq, done, quotient, remainder, hilo and dbz are all 0.

## Timing
- Start accepted at edge 0. CALC occupies edges 1..WIDTH, FIX is the next cycle, and done is high for the cycle after edge WIDTH+1, i.e. latency WIDTH+2 cycles. This is 34 for WIDTH = 32.
- done is high for exactly one cycle. quotient, remainder and hilo are valid from that cycle and stable until the next accepted start's FIX.
- Back-to-back: a new start may be sampled in the cycle done is high. IDLE is re-entered that cycle, giving a throughput of one operation per WIDTH+2 cycles.
- Flush takes effect at the next edge. busy and stallreq are low the following cycle.

## Configuration
- DIV_DBZ_EN defined:
  - A zero divisor at start skips CALC and goes straight to FIX. done appears 2 cycles after start.
  - Results: quotient = all ones, remainder = dividend unmodified, dbz = 1 with done and held with the results.
- DIV_DBZ_EN undefined:
  - No dbz port and no early-out.
  - A zero divisor runs the full WIDTH+2 latency with the results defined in Operation.

## Structure
- Shared package div_pkg:
  - state enum (IDLE, CALC, FIX)
  - DIV_CNT_W = $clog2(WIDTH)
  - helper function packing {rem, quo} into hilo
- One sub-module, div_step: combinational single iteration. Inputs: partial remainder, next dividend bit, divisor. Outputs: new remainder and quotient bit.
- div_iter holds the FSM, counter, operand/sign registers and result registers.

## Test plan
- Unsigned 100 ÷ 7, WIDTH = 32 → done exactly 34 cycles after start, quotient 14, remainder 2, hilo = 0x00000002_0000000E. stallreq high for the whole window.
- Signed −7 ÷ 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 ÷ −2 → quotient 0xFFFFFFFD, remainder 1.
- Signed 0x80000000 ÷ 0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF ÷ 1 → quotient 0xFFFFFFFF, remainder 0.
- Flush asserted 10 cycles after start → no done pulse, busy/stallreq low next cycle, previous results unchanged. A new start of 9 ÷ 3 then gives quotient 3, remainder 0.
- Divisor 0, dividend 0x1234:
  - With DIV_DBZ_EN: done 2 cycles after start, dbz = 1, quotient 0xFFFFFFFF, remainder 0x1234.
  - Without DIV_DBZ_EN: done after 34 cycles with the same values.
- Reset asserted mid-CALC → all outputs 0 immediately. start during busy → ignored, and the original result is delivered unchanged.
